// File: rtl/i2s_array_rx.sv
// Multi-line I2S / left-justified receiver: NUM_LINES stereo data lines on a shared bit clock and WS.
// Optional half-frame length checking is enabled by defining I2S_ARRAY_RX_FRAME_CHECK_EN.
module i2s_array_rx #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned DATAWIDTH = 24,
  parameter int unsigned SLOTWIDTH = 32
) (
  input  logic                           clk_mic,
  input  logic                           rst_mic_n,
  input  logic                           en,
  input  logic                           mode,
  input  logic                           WS,
  input  logic [NUM_LINES-1:0]           DATA,
  output logic [NUM_LINES*DATAWIDTH-1:0] L_DATA,
  output logic [NUM_LINES*DATAWIDTH-1:0] R_DATA,
  output logic                           frame_valid,
  output logic                           frame_err,
  output logic [15:0]                    frame_cnt
);

  localparam int unsigned CW = $clog2(SLOTWIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(SLOTWIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t state, state_nxt;
  logic ws_d, mode_q;
  logic [CW-1:0] bit_cnt;
  logic [NUM_LINES-1:0][DATAWIDTH-1:0] sr_l, sr_r;

  logic fall_c, rise_c, edge_c, err_c;
  logic enter_left_c, mode_eff_c, in_win_c, cap_l_c, cap_r_c, load_c;
  logic [CW-1:0] raw_idx_c, idx_c, load_idx_c;

  // WS edge detection and bit index of the current cycle within its half
  always_comb begin
    fall_c    = ws_d & ~WS;
    rise_c    = ~ws_d & WS;
    edge_c    = fall_c | rise_c;
    raw_idx_c = bit_cnt + CW'(1);
    idx_c     = edge_c ? '0 : ((bit_cnt == LAST_IDX) ? LAST_IDX : raw_idx_c);
  end

`ifdef I2S_ARRAY_RX_FRAME_CHECK_EN
  // Short half: closing edge before the last slot bit; long half: no edge after it
  always_comb begin
    err_c = 1'b0;
    if (en && (state != IDLE)) begin
      if (((state == LEFT) && rise_c) || ((state == RIGHT) && fall_c))
        err_c = (bit_cnt != LAST_IDX);
      else if (!edge_c && (bit_cnt == LAST_IDX))
        err_c = 1'b1;
    end
  end
`else
  assign err_c = 1'b0;
`endif

  always_ff @(posedge clk_mic) begin
    if (!rst_mic_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en || err_c) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (fall_c) state_nxt = LEFT;
        LEFT:    if (rise_c) state_nxt = RIGHT;
        RIGHT:   if (fall_c) state_nxt = LEFT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The fall that opens a frame already uses the newly latched mode for bit 0
  always_comb begin
    enter_left_c = 1'b0;
    mode_eff_c   = mode_q;
    in_win_c     = 1'b0;
    enter_left_c = (state_nxt == LEFT) && (state != LEFT);
    mode_eff_c   = enter_left_c ? mode : mode_q;
    if (mode_eff_c) in_win_c = (idx_c < CW'(DATAWIDTH));
    else            in_win_c = (idx_c != '0) && (idx_c <= CW'(DATAWIDTH));
    cap_l_c      = in_win_c && (state_nxt == LEFT);
    cap_r_c      = in_win_c && (state_nxt == RIGHT);
    load_idx_c   = mode_q ? CW'(DATAWIDTH) : CW'(DATAWIDTH + 1);
    load_c       = en && !err_c && (state == RIGHT) && (raw_idx_c == load_idx_c);
  end

  always_ff @(posedge clk_mic) begin
    if (!rst_mic_n) begin
      ws_d        <= 1'b0;
      mode_q      <= 1'b0;
      bit_cnt     <= '0;
      sr_l        <= '0;
      sr_r        <= '0;
      L_DATA      <= '0;
      R_DATA      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      ws_d        <= WS;
      bit_cnt     <= idx_c;
      frame_valid <= load_c;
      frame_err   <= err_c;
      if (enter_left_c) mode_q <= mode;
      for (int k = 0; k < NUM_LINES; k++) begin
        if (cap_l_c) sr_l[k] <= DATAWIDTH'({sr_l[k], DATA[k]});
        if (cap_r_c) sr_r[k] <= DATAWIDTH'({sr_r[k], DATA[k]});
      end
      if (load_c) begin
        L_DATA    <= sr_l;
        R_DATA    <= sr_r;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
